multi_alarm_clock: RTL

//  Parametrised successor to the single-alarm BCD clock: 24h BCD time-of-day counter

---
 rtl/alarm_clock_pkg.sv | 48 ++++
 rtl/multi_alarm_clock_channel.sv | 90 +++++++++
 rtl/multi_alarm_clock.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared types, limits and BCD helpers for the multi-alarm clock.
package alarm_clock_pkg;

  localparam int unsigned MAX_H       = 23;
  localparam int unsigned MAX_M       = 59;
  localparam int unsigned MIN_PER_DAY = 1440;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RINGING = 2'd1,
    CH_SNOOZED = 2'd2
  } ch_state_t;

  function automatic int unsigned hhmm_to_min(hhmm_t t);
    return (32'(t.h1) * 10 + 32'(t.h0)) * 60 + 32'(t.m1) * 10 + 32'(t.m0);
  endfunction

  // Every digit must be decimal and the pair must be a real 24h time.
  function automatic logic bcd_valid(hhmm_t t);
    return (t.h0 <= 4'd9) && (t.m1 <= 4'd9) && (t.m0 <= 4'd9) &&
           (32'(t.h1) * 10 + 32'(t.h0) <= MAX_H) &&
           (32'(t.m1) * 10 + 32'(t.m0) <= MAX_M);
  endfunction

  // Adds minutes to an HH:MM value, wrapping at midnight.
  function automatic hhmm_t hhmm_add_min(hhmm_t t, int unsigned add);
    int unsigned total;
    int unsigned h;
    int unsigned m;
    hhmm_t       r;
    total = (hhmm_to_min(t) + add) % MIN_PER_DAY;
    h     = total / 60;
    m     = total % 60;
    r.h1  = 2'(h / 10);
    r.h0  = 4'(h % 10);
    r.m1  = 4'(m / 10);
    r.m0  = 4'(m % 10);
    return r;
  endfunction

endpackage

// File: rtl/multi_alarm_clock_channel.sv
// One alarm channel: stored HH:MM, enable, ring/snooze state machine.
module alarm_channel
  import alarm_clock_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick,
  input  logic  time_upd,
  input  hhmm_t next_hhmm,
  input  logic  next_sec_zero,
  input  hhmm_t now_hhmm,
  input  logic  ld,
  input  hhmm_t ld_hhmm,
  input  logic  ld_en,
  input  logic  stop,
  input  logic  snooze,
  output logic  ringing
);

  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

  hhmm_t     alarm_q;
  hhmm_t     target_q;
  logic      en_q;
  ch_state_t state_q;
  logic [7:0] ring_cnt_q;
  logic      hit_alarm;
  logic      hit_target;

  // Matches fire only when time actually moves onto HH:MM:00, so a slow
  // prescaler cannot re-trigger a channel that was just stopped.
  always_comb begin
    hit_alarm  = time_upd && next_sec_zero && (next_hhmm == alarm_q);
    hit_target = time_upd && next_sec_zero && (next_hhmm == target_q);
  end

  // Alarm storage and channel state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q    <= '0;
      target_q   <= '0;
      en_q       <= 1'b0;
      state_q    <= CH_IDLE;
      ring_cnt_q <= '0;
    end else if (ld && !ld_en) begin
      alarm_q <= ld_hhmm;
      en_q    <= 1'b0;
      state_q <= CH_IDLE;
    end else begin
      if (ld) begin
        alarm_q <= ld_hhmm;
        en_q    <= 1'b1;
      end
      case (state_q)
        CH_IDLE: begin
          if (en_q && hit_alarm) begin
            state_q    <= CH_RINGING;
            ring_cnt_q <= '0;
          end
        end
        CH_RINGING: begin
          if (stop) begin
            state_q <= CH_IDLE;
          end else if (snooze) begin
            state_q  <= CH_SNOOZED;
            target_q <= hhmm_add_min(now_hhmm, SNOOZE_MIN);
          end else if (tick) begin
            if (ring_cnt_q == RING_LAST) state_q <= CH_IDLE;
            else ring_cnt_q <= ring_cnt_q + 8'd1;
          end
        end
        CH_SNOOZED: begin
          if (stop) begin
            state_q <= CH_IDLE;
          end else if (hit_target) begin
            state_q    <= CH_RINGING;
            ring_cnt_q <= '0;
          end
        end
        default: state_q <= CH_IDLE;
      endcase
    end
  end

  assign ringing = (state_q == CH_RINGING);

endmodule

// File: rtl/multi_alarm_clock.sv
// 24h BCD clock with prescaler, load decode and NUM_ALARMS alarm channels.
module multi_alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter  int unsigned NUM_ALARMS = 4,
  parameter  int unsigned CLK_DIV    = 1,
  parameter  int unsigned SNOOZE_MIN = 5,
  parameter  int unsigned RING_SEC   = 60,
  localparam int unsigned SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       H_in1,
  input  logic [3:0]       H_in0,
  input  logic [3:0]       M_in1,
  input  logic [3:0]       M_in0,
  input  logic             LD_time,
  input  logic             LD_alarm,
  input  logic [SEL_W-1:0] AL_SEL,
  input  logic             AL_EN,
  input  logic             STOP_al,
  input  logic             SNOOZE,
  output logic             Alarm,
  output logic [SEL_W-1:0] Alarm_id,
  output logic [1:0]       H_out1,
  output logic [3:0]       H_out0,
  output logic [3:0]       M_out1,
  output logic [3:0]       M_out0,
  output logic [3:0]       S_out1,
  output logic [3:0]       S_out0
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]      div_q;
  logic                  tick;
  hhmm_t                 ld_hhmm;
  hhmm_t                 now_hhmm;
  hhmm_t                 next_hhmm;
  logic [3:0]            next_s1;
  logic [3:0]            next_s0;
  logic                  ld_time_ok;
  logic                  ld_alarm_ok;
  logic                  time_upd;
  logic                  next_sec_zero;
  logic [NUM_ALARMS-1:0] ringing;

  assign ld_hhmm     = {H_in1, H_in0, M_in1, M_in0};
  assign now_hhmm    = {H_out1, H_out0, M_out1, M_out0};
  assign tick        = (div_q == DIV_LAST);
  assign ld_time_ok  = LD_time && bcd_valid(ld_hhmm);
  assign ld_alarm_ok = LD_alarm && bcd_valid(ld_hhmm) && !ld_time_ok &&
                       (32'(AL_SEL) < NUM_ALARMS);
  assign time_upd      = ld_time_ok || tick;
  assign next_sec_zero = (next_s1 == 4'd0) && (next_s0 == 4'd0);

  // Second prescaler; a time load restarts the second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= '0;
    else if (time_upd) div_q <= '0;
    else div_q <= div_q + DIV_W'(1);
  end

  // Next displayed time: load wins over tick; ripple carry s->m->h->day.
  always_comb begin
    next_hhmm = now_hhmm;
    next_s1   = S_out1;
    next_s0   = S_out0;
    if (ld_time_ok) begin
      next_hhmm = ld_hhmm;
      next_s1   = '0;
      next_s0   = '0;
    end else if (tick) begin
      next_s0 = (S_out0 == 4'd9) ? 4'd0 : S_out0 + 4'd1;
      if (S_out0 == 4'd9) begin
        next_s1 = (S_out1 == 4'd5) ? 4'd0 : S_out1 + 4'd1;
        if (S_out1 == 4'd5) begin
          next_hhmm.m0 = (M_out0 == 4'd9) ? 4'd0 : M_out0 + 4'd1;
          if (M_out0 == 4'd9) begin
            next_hhmm.m1 = (M_out1 == 4'd5) ? 4'd0 : M_out1 + 4'd1;
            if (M_out1 == 4'd5) begin
              if (H_out1 == 2'd2 && H_out0 == 4'd3) begin
                next_hhmm.h1 = '0;
                next_hhmm.h0 = '0;
              end else if (H_out0 == 4'd9) begin
                next_hhmm.h1 = H_out1 + 2'd1;
                next_hhmm.h0 = '0;
              end else begin
                next_hhmm.h0 = H_out0 + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Time-of-day registers driving the display digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      H_out1 <= '0;
      H_out0 <= '0;
      M_out1 <= '0;
      M_out0 <= '0;
      S_out1 <= '0;
      S_out0 <= '0;
    end else begin
      H_out1 <= next_hhmm.h1;
      H_out0 <= next_hhmm.h0;
      M_out1 <= next_hhmm.m1;
      M_out0 <= next_hhmm.m0;
      S_out1 <= next_s1;
      S_out0 <= next_s0;
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_SEC  (RING_SEC)
    ) u_ch (
      .clk          (clk),
      .rst_n        (reset),
      .tick         (tick),
      .time_upd     (time_upd),
      .next_hhmm    (next_hhmm),
      .next_sec_zero(next_sec_zero),
      .now_hhmm     (now_hhmm),
      .ld           (ld_alarm_ok && (AL_SEL == SEL_W'(i))),
      .ld_hhmm      (ld_hhmm),
      .ld_en        (AL_EN),
      .stop         (STOP_al),
      .snooze       (SNOOZE),
      .ringing      (ringing[i])
    );
  end

  // Alarm line and lowest-index priority encode of ringing channels.
  always_comb begin
    Alarm    = |ringing;
    Alarm_id = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (ringing[NUM_ALARMS-1-i]) Alarm_id = SEL_W'(NUM_ALARMS - 1 - i);
    end
  end

endmodule
